// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and state type for the load/store initiator
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int DW  = 32;
  localparam int BEW = DW / 8;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign/zero-extends it
module load_extend
  import lsu_pkg::*;
(
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    offset,
  input  logic [2:0]    funct3,
  output logic [DW-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{offset, 3'b000} +: 8];
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];
  // unknown encodings never reach here, but return 0 rather than garbage
  always_comb
    data = funct3 == F3_B  ? {{24{b[7]}}, b}  :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_BU ? {24'b0, b}       :
           funct3 == F3_HU ? {16'b0, h}       :
           funct3 == F3_W  ? rdata            : '0;
endmodule

// File: rtl/load_store_initiator.sv
// load_store_initiator: MEM-stage req/gnt+rvalid bus initiator with byte enables and load extension
module load_store_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemReadM,
  input  logic          MemWriteM,
  input  logic [2:0]    Funct3M,
  input  logic [31:0]   ALU_ResultM,
  input  logic [31:0]   WriteDataM,
  output logic          StallM,
  output logic [31:0]   LoadDataM,
  output logic          LoadDoneM,
  output logic          AccessFaultM,
  output logic          BusErrM,
  output logic          bus_req,
  output logic          bus_we,
  output logic [31:0]   bus_addr,
  output logic [BEW-1:0] bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic access, legal_f3, misal, ok, launch, rd_done, wr_done, timeout, bus_err;
  logic [3:0] be;
  logic [31:0] wdata, ext;
  assign access   = MemReadM | MemWriteM;
  assign legal_f3 = MemWriteM ? Funct3M inside {F3_B, F3_H, F3_W} : Funct3M inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign misal    = (Funct3M[1:0] == 2'b01 && ALU_ResultM[0]) || (Funct3M[1:0] == 2'b10 && |ALU_ResultM[1:0]);
  assign ok       = legal_f3 & ~misal;
  assign launch   = state == S_IDLE && access && ok;
  assign rd_done  = ((state == S_REQ && bus_gnt && !bus_we) || state == S_WAIT) && bus_rvalid;
  assign wr_done  = state == S_REQ && bus_gnt && bus_we;
  assign timeout  = (state == S_REQ || state == S_WAIT) && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus_err  = timeout & ~rd_done & ~wr_done;
  assign bus_req  = state == S_REQ;
  assign StallM   = ~rst & (launch | state == S_REQ | state == S_WAIT);
  assign AccessFaultM = ~rst & state == S_IDLE & access & ~ok;
  // store lane replication and byte enables; loads always fetch the whole word
  always_comb begin
    wdata = Funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} : Funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
    be    = !MemWriteM ? 4'b1111 : Funct3M[1:0] == 2'b00 ? 4'b0001 << ALU_ResultM[1:0] :
            Funct3M[1:0] == 2'b01 ? (ALU_ResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  // completion (data or timeout) wins over a plain grant; DONE always returns to IDLE
  always_comb begin
    nxt = state;
    if (state == S_IDLE) nxt = launch ? S_REQ : S_IDLE;
    else if (state == S_DONE) nxt = S_IDLE;
    else if (rd_done || wr_done || timeout) nxt = S_DONE;
    else if (state == S_REQ && bus_gnt) nxt = S_WAIT;
  end
  load_extend u_ext (.rdata(bus_rdata), .offset(off_q), .funct3(f3_q), .data(ext));
  // state, latched request, timeout counter and registered completion outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      LoadDoneM <= 1'b0;
      BusErrM   <= 1'b0;
      LoadDataM <= '0;
    end else begin
      state     <= nxt;
      cnt       <= state == S_IDLE ? '0 : cnt + 1'b1;
      LoadDoneM <= nxt == S_DONE;
      BusErrM   <= nxt == S_DONE && bus_err;
      LoadDataM <= nxt == S_DONE && rd_done ? ext : '0;
      if (launch) begin
        f3_q      <= Funct3M;
        off_q     <= ALU_ResultM[1:0];
        bus_we    <= MemWriteM;
        bus_addr  <= {2'b00, ALU_ResultM[31:2]};
        bus_be    <= be;
        bus_wdata <= wdata;
      end
    end
endmodule

// File: tb/tb_load_store_initiator.sv
// tb_load_store_initiator: directed and randomized checks against a byte-level memory-semantics model
module tb_load_store_initiator;
  logic clk = 0, rst = 1;
  logic MemReadM = 0, MemWriteM = 0;
  logic [2:0] Funct3M = 0;
  logic [31:0] ALU_ResultM = 0, WriteDataM = 0;
  logic StallM, LoadDoneM, AccessFaultM, BusErrM, bus_req, bus_we;
  logic [31:0] LoadDataM, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic bus_gnt = 0, bus_rvalid = 0;
  logic [31:0] bus_rdata = 0;
  int checks = 0, errors = 0;
  logic [31:0] last;

  load_store_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .StallM(StallM), .LoadDataM(LoadDataM),
    .LoadDoneM(LoadDoneM), .AccessFaultM(AccessFaultM), .BusErrM(BusErrM), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit exp_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit enc = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return enc && (a % nbytes(f3) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    int off = int'(a % 4);
    int m = ((1 << n) - 1) << off;
    return st ? m[3:0] : 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int n = nbytes(f3);
    longint m = longint'(1) << (8 * n);
    longint v = (longint'(w) >> (8 * int'(a % 4))) % m;
    if (f3 < 3'd4 && v >= m / 2) v -= m;
    return v[31:0];
  endfunction

  task automatic chk_bus(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    chk1("req_held", bus_req, 1'b1);
    chk1("req_stall", StallM, 1'b1);
    chk1("req_we", bus_we, st);
    chk("req_addr", bus_addr, a >> 2);
    chk("req_be", 32'(bus_be), 32'(exp_be(st, f3, a)));
    if (st) chk("req_wdata", bus_wdata, exp_wdata(f3, wd));
  endtask

  task automatic xact(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdw, input int gd, input int rvd,
                      output logic [31:0] got);
    bit st = wr;
    got = '0;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALU_ResultM = a; WriteDataM = wd;
    #1;
    if (!exp_legal(st, f3, a)) begin
      chk1("fault_flag", AccessFaultM, 1'b1);
      chk1("fault_stall", StallM, 1'b0);
      chk1("fault_req", bus_req, 1'b0);
      @(posedge clk); #1;
      chk1("fault_req_next", bus_req, 1'b0);
      chk1("fault_nodone", LoadDoneM, 1'b0);
      MemReadM = 0; MemWriteM = 0;
      return;
    end
    chk1("launch_stall", StallM, 1'b1);
    chk1("launch_nofault", AccessFaultM, 1'b0);
    @(posedge clk); #1;
    repeat (gd) begin
      chk_bus(st, f3, a, wd);
      ALU_ResultM = $urandom; WriteDataM = $urandom;
      @(posedge clk); #1;
    end
    chk_bus(st, f3, a, wd);
    bus_gnt = 1;
    if (!st && rvd == 0) begin bus_rvalid = 1; bus_rdata = rdw; end
    @(posedge clk); #1;
    bus_gnt = 0; bus_rvalid = 0;
    if (!st && rvd > 0) begin
      repeat (rvd - 1) begin
        chk1("wait_req", bus_req, 1'b0);
        chk1("wait_stall", StallM, 1'b1);
        chk1("wait_nodone", LoadDoneM, 1'b0);
        @(posedge clk); #1;
      end
      bus_rvalid = 1; bus_rdata = rdw;
      @(posedge clk); #1;
      bus_rvalid = 0;
    end
    got = LoadDataM;
    chk1("done_pulse", LoadDoneM, 1'b1);
    chk1("done_stall", StallM, 1'b0);
    chk1("done_nobuserr", BusErrM, 1'b0);
    chk("done_data", LoadDataM, st ? 32'd0 : exp_load(f3, a, rdw));
    MemReadM = 0; MemWriteM = 0; bus_rdata = $urandom;
    @(posedge clk); #1;
    chk1("after_done", LoadDoneM, 1'b0);
    chk("after_data", LoadDataM, 32'd0);
  endtask

  initial begin
    int n;
    bit found;
    #1;
    chk1("rst_req", bus_req, 1'b0);
    chk1("rst_stall", StallM, 1'b0);
    chk1("rst_done", LoadDoneM, 1'b0);
    chk1("rst_buserr", BusErrM, 1'b0);
    chk("rst_data", LoadDataM, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, last);
    xact(1, 0, 3'b000, 32'h23, 32'h0, 32'h80FF7F01, 0, 0, last);
    chk("lb_const", last, 32'hFFFFFF80);
    xact(1, 0, 3'b100, 32'h23, 32'h0, 32'h80FF7F01, 0, 0, last);
    chk("lbu_const", last, 32'h00000080);
    xact(0, 1, 3'b001, 32'h06, 32'h1234ABCD, 32'h0, 3, 0, last);
    xact(1, 0, 3'b001, 32'h06, 32'h0, 32'h80015555, 0, 2, last);
    chk("lh_const", last, 32'hFFFF8001);
    xact(1, 0, 3'b010, 32'h05, 32'h0, 32'h0, 0, 0, last);
    xact(1, 0, 3'b011, 32'h08, 32'h0, 32'h0, 0, 0, last);

    MemReadM = 1; Funct3M = 3'b010; ALU_ResultM = 32'h40;
    @(posedge clk); #1;
    bus_gnt = 1;
    n = 1; found = 0;
    while (!found && n < 20) begin
      @(posedge clk); #1;
      bus_gnt = 0;
      n++;
      found = LoadDoneM;
    end
    chk("timeout_cycle", 32'(n), 32'd9);
    chk1("timeout_buserr", BusErrM, 1'b1);
    chk("timeout_data", LoadDataM, 32'd0);
    MemReadM = 0;
    @(posedge clk); #1;
    chk1("timeout_idle_done", LoadDoneM, 1'b0);
    chk1("timeout_idle_err", BusErrM, 1'b0);
    chk1("timeout_idle_stall", StallM, 1'b0);

    MemReadM = 1; Funct3M = 3'b010; ALU_ResultM = 32'h80;
    @(posedge clk); #1;
    bus_gnt = 1;
    @(posedge clk); #1;
    bus_gnt = 0;
    chk1("wait_before_rst", StallM, 1'b1);
    #2 rst = 1;
    #1;
    chk1("arst_req", bus_req, 1'b0);
    chk1("arst_stall", StallM, 1'b0);
    chk1("arst_done", LoadDoneM, 1'b0);
    chk("arst_be", 32'(bus_be), 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    MemReadM = 0;
    @(posedge clk); #1;
    rst = 0;
    bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_rvalid = 0;
    chk1("late_rvalid_done", LoadDoneM, 1'b0);
    @(posedge clk); #1;
    chk1("late_rvalid_done2", LoadDoneM, 1'b0);
    chk("late_rvalid_data", LoadDataM, 32'd0);

    for (int i = 0; i < 60; i++) begin
      int op = $urandom_range(1, 3);
      xact(op[0], op[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
           $urandom_range(0, 3), $urandom_range(0, 3), last);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
